// File: rtl/nway_assoc_cache_if.sv
// Request/response bundle for nway_assoc_cache.
// enable qualifies a request for exactly one cycle; there is no back-pressure, all responses are
// combinational on that cycle's request and the array update takes effect on the next clock edge.
interface nway_assoc_cache_if #(
    parameter int TAG_W    = 5,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    parameter int DATA_W   = 16
);
    logic                enable;
    logic                comp;
    logic                write;
    logic                valid_in;
    logic [TAG_W-1:0]    tag_in;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic [DATA_W-1:0]   data_in;
    logic [TAG_W-1:0]    tag_out;
    logic [DATA_W-1:0]   data_out;
    logic                hit;
    logic                dirty;
    logic                valid;
    logic                err;
    logic [15:0]         hit_cnt;
    logic [15:0]         miss_cnt;

    modport master (
        output enable, comp, write, valid_in, tag_in, index, offset, data_in,
        input  tag_out, data_out, hit, dirty, valid, err, hit_cnt, miss_cnt
    );
    modport slave (
        input  enable, comp, write, valid_in, tag_in, index, offset, data_in,
        output tag_out, data_out, hit, dirty, valid, err, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/nway_assoc_cache.sv
// N-way set-associative cache array with per-set tree PLRU and a fill-way lock.
// Optional hit/miss statistics counters are built when CACHE_STATS_EN is defined.
module nway_assoc_cache #(
    parameter int WAYS     = 2,
    parameter int TAG_W    = 5,
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    parameter int DATA_W   = 16
) (
    input logic               clk,
    input logic               rst,
    nway_assoc_cache_if.slave bus
);
    localparam int SETS   = 1 << INDEX_W;
    localparam int WORD_W = OFFSET_W - 1;
    localparam int WORDS  = 1 << WORD_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    logic [TAG_W-1:0]  r_tag  [WAYS][SETS];
    logic [DATA_W-1:0] r_data [WAYS][SETS*WORDS];
    logic [SETS-1:0]   r_valid [WAYS];
    logic [SETS-1:0]   r_dirty [WAYS];
    logic [PLRU_W-1:0] r_plru [SETS];
    logic              r_lock_vld;
    logic [INDEX_W-1:0] r_lock_idx;
    logic [WAY_W-1:0]  r_lock_way;

    logic                      w_go;
    logic [INDEX_W+WORD_W-1:0] w_addr;
    logic                      w_hit;
    logic [WAY_W-1:0]          w_hit_way;
    logic                      w_inv_found;
    logic [WAY_W-1:0]          w_inv_way;
    logic [PLRU_W-1:0]         w_plru_cur;
    logic [PLRU_W-1:0]         w_plru_nxt;
    logic [WAY_W-1:0]          w_plru_vic;
    logic [WAY_W-1:0]          w_victim;
    logic [WAY_W-1:0]          w_sel;
    logic [WAY_W-1:0]          w_upd_way;
    logic                      w_plru_we;
    logic                      w_data_we;
    logic                      w_show;

    assign w_go   = bus.enable & ~bus.offset[0];
    assign w_addr = {bus.index, bus.offset[OFFSET_W-1:1]};

    // Scan downwards so the lowest-numbered matching / invalid way wins.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (r_valid[w][bus.index] && (r_tag[w][bus.index] == bus.tag_in)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!r_valid[w][bus.index]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
    end

    assign w_plru_cur = r_plru[bus.index];

    generate
        if (WAYS == 2) begin : g_plru2
            assign w_plru_vic = w_plru_cur;
            assign w_plru_nxt = ~w_upd_way;
        end else begin : g_plru4
            // bit0 picks the half, bit1/bit2 pick the way inside the low/high half.
            assign w_plru_vic = w_plru_cur[0] ? {1'b1, w_plru_cur[2]} : {1'b0, w_plru_cur[1]};
            assign w_plru_nxt = w_upd_way[1] ? {~w_upd_way[0], w_plru_cur[1], 1'b0}
                                             : {w_plru_cur[2], ~w_upd_way[0], 1'b1};
        end
    endgenerate

    // A held lock keeps every word of a line fill in the same way.
    assign w_victim  = (r_lock_vld && !bus.comp && (bus.index == r_lock_idx)) ? r_lock_way
                     : (w_inv_found ? w_inv_way : w_plru_vic);
    assign w_sel     = (bus.comp && !bus.write) ? w_hit_way : w_victim;
    assign w_upd_way = bus.comp ? w_hit_way : w_victim;
    assign w_plru_we = w_go & (bus.comp ? w_hit : bus.write);
    assign w_data_we = w_go & bus.write & (bus.comp ? w_hit : 1'b1);
    assign w_show    = w_go & ~(bus.comp & ~bus.write & ~w_hit);

    assign bus.err      = bus.enable & bus.offset[0];
    assign bus.hit      = w_go & bus.comp & w_hit;
    assign bus.tag_out  = w_show ? r_tag[w_sel][bus.index] : '0;
    assign bus.data_out = w_show ? r_data[w_sel][w_addr] : '0;
    assign bus.dirty    = w_show & r_dirty[w_sel][bus.index];
    assign bus.valid    = w_show & r_valid[w_sel][bus.index];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int w = 0; w < WAYS; w++) begin
                r_valid[w] <= '0;
                r_dirty[w] <= '0;
            end
            for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
            r_lock_vld <= 1'b0;
            r_lock_idx <= '0;
            r_lock_way <= '0;
        end else if (w_go) begin
            if (w_data_we) begin
                if (bus.comp) begin
                    r_dirty[w_upd_way][bus.index] <= 1'b1;
                end else begin
                    r_valid[w_upd_way][bus.index] <= bus.valid_in;
                    r_dirty[w_upd_way][bus.index] <= 1'b0;
                end
            end
            if (w_plru_we) r_plru[bus.index] <= w_plru_nxt;
            if (bus.comp) begin
                r_lock_vld <= 1'b0;
            end else begin
                r_lock_vld <= 1'b1;
                r_lock_idx <= bus.index;
                r_lock_way <= w_victim;
            end
        end
    end

    // Tag and data storage carry no reset; valid bits qualify them.
    always_ff @(posedge clk) begin
        if (w_data_we) begin
            r_data[w_upd_way][w_addr] <= bus.data_in;
            if (!bus.comp) r_tag[w_upd_way][bus.index] <= bus.tag_in;
        end
    end

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (w_go && bus.comp) begin
            if (w_hit) begin
                if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
            end else begin
                if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`else
    assign bus.hit_cnt  = '0;
    assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_nway_assoc_cache.sv
// Scoreboard bench: a 2-way and a 4-way instance share one stimulus stream, each checked against
// an array-based reference model of the cache rules.
module tb_nway_assoc_cache;
    localparam int EXP_W = 57;  // {hit_cnt, miss_cnt, err, hit, dirty, valid, tag[4:0], data[15:0]}

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        t_en = 1'b0, t_comp = 1'b0, t_write = 1'b0, t_vin = 1'b0;
    logic [4:0]  t_tag = '0;
    logic [7:0]  t_idx = '0;
    logic [2:0]  t_off = '0;
    logic [15:0] t_data = '0;

    nway_assoc_cache_if #(.TAG_W(5), .INDEX_W(8), .OFFSET_W(3), .DATA_W(16)) bus2 ();
    nway_assoc_cache_if #(.TAG_W(5), .INDEX_W(8), .OFFSET_W(3), .DATA_W(16)) bus4 ();

    assign bus2.enable = t_en;   assign bus4.enable = t_en;
    assign bus2.comp = t_comp;   assign bus4.comp = t_comp;
    assign bus2.write = t_write; assign bus4.write = t_write;
    assign bus2.valid_in = t_vin; assign bus4.valid_in = t_vin;
    assign bus2.tag_in = t_tag;  assign bus4.tag_in = t_tag;
    assign bus2.index = t_idx;   assign bus4.index = t_idx;
    assign bus2.offset = t_off;  assign bus4.offset = t_off;
    assign bus2.data_in = t_data; assign bus4.data_in = t_data;

    nway_assoc_cache #(.WAYS(2), .TAG_W(5), .INDEX_W(8), .OFFSET_W(3), .DATA_W(16))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));
    nway_assoc_cache #(.WAYS(4), .TAG_W(5), .INDEX_W(8), .OFFSET_W(3), .DATA_W(16))
        dut4 (.clk(clk), .rst(rst), .bus(bus4));

    // ---------------- reference model (k=0: 2-way, k=1: 4-way) ----------------
    bit          m_valid [2][256][4];
    bit          m_dirty [2][256][4];
    logic [4:0]  m_tag   [2][256][4];
    bit          m_tk    [2][256][4];
    logic [15:0] m_data  [2][256][4][4];
    bit          m_dk    [2][256][4][4];
    logic [2:0]  m_plru  [2][256];
    bit          m_lock  [2];
    int          m_lidx  [2];
    int          m_lway  [2];
    int          m_hc    [2];
    int          m_mc    [2];

    int n_checks = 0;
    int n_pass   = 0;
    logic [2*EXP_W-1:0] q2[$];
    logic [2*EXP_W-1:0] q4[$];

    function automatic int nw(int k);
        return (k == 0) ? 2 : 4;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 256; s++) begin
                m_plru[k][s] = 3'b000;
                for (int w = 0; w < 4; w++) begin
                    m_valid[k][s][w] = 1'b0;
                    m_dirty[k][s][w] = 1'b0;
                end
            end
            m_lock[k] = 1'b0;
            m_hc[k] = 0;
            m_mc[k] = 0;
        end
    endfunction

    function automatic int m_victim(int k, int idx, bit comp);
        if (m_lock[k] && !comp && idx == m_lidx[k]) return m_lway[k];
        for (int w = 0; w < nw(k); w++) if (!m_valid[k][idx][w]) return w;
        if (k == 0) return int'(m_plru[k][idx][0]);
        return m_plru[k][idx][0] ? 2 + int'(m_plru[k][idx][2]) : int'(m_plru[k][idx][1]);
    endfunction

    function automatic void m_touch(int k, int idx, int w);
        if (k == 0) begin
            m_plru[k][idx][0] = (w == 0);
        end else if (w < 2) begin
            m_plru[k][idx][0] = 1'b1;
            m_plru[k][idx][1] = (w == 0);
        end else begin
            m_plru[k][idx][0] = 1'b0;
            m_plru[k][idx][2] = (w == 2);
        end
    endfunction

    // Returns {mask, expected} for the current request, then applies the request to the model.
    function automatic logic [2*EXP_W-1:0] m_step(int k);
        logic [EXP_W-1:0] e, m;
        int idx, wd, hw, v, sel;
        e = '0;
        m = '1;
        idx = int'(t_idx);
        wd = int'(t_off) / 2;
        e[56:41] = 16'(m_hc[k]);
        e[40:25] = 16'(m_mc[k]);
        if (t_en && t_off[0]) begin
            e[24] = 1'b1;
        end else if (t_en) begin
            hw = -1;
            for (int w = 0; w < nw(k); w++)
                if (hw < 0 && m_valid[k][idx][w] && m_tag[k][idx][w] == t_tag) hw = w;
            v = m_victim(k, idx, t_comp);
            sel = (t_comp && !t_write) ? hw : v;
            if (sel >= 0) begin
                e[23] = t_comp && (hw >= 0);
                e[22] = m_dirty[k][idx][sel];
                e[21] = m_valid[k][idx][sel];
                e[20:16] = m_tag[k][idx][sel];
                e[15:0] = m_data[k][idx][sel][wd];
                if (!m_tk[k][idx][sel]) m[20:16] = '0;
                if (!m_dk[k][idx][sel][wd]) m[15:0] = '0;
            end
            if (t_comp) begin
`ifdef CACHE_STATS_EN
                if (hw >= 0) begin if (m_hc[k] < 65535) m_hc[k]++; end
                else if (m_mc[k] < 65535) m_mc[k]++;
`endif
                if (hw >= 0) begin
                    if (t_write) begin
                        m_data[k][idx][hw][wd] = t_data;
                        m_dk[k][idx][hw][wd] = 1'b1;
                        m_dirty[k][idx][hw] = 1'b1;
                    end
                    m_touch(k, idx, hw);
                end
                m_lock[k] = 1'b0;
            end else begin
                if (t_write) begin
                    m_data[k][idx][v][wd] = t_data;
                    m_dk[k][idx][v][wd] = 1'b1;
                    m_tag[k][idx][v] = t_tag;
                    m_tk[k][idx][v] = 1'b1;
                    m_valid[k][idx][v] = t_vin;
                    m_dirty[k][idx][v] = 1'b0;
                    m_touch(k, idx, v);
                end
                m_lock[k] = 1'b1;
                m_lidx[k] = idx;
                m_lway[k] = v;
            end
        end
        return {m, e};
    endfunction

    // ---------------- monitors ----------------
    task automatic mon_cmp(input string name, input logic [EXP_W-1:0] act, input logic [2*EXP_W-1:0] pk);
        logic [EXP_W-1:0] e, m;
        e = pk[EXP_W-1:0];
        m = pk[2*EXP_W-1:EXP_W];
        n_checks++;
        if (((act ^ e) & m) != '0)
            $display("FAIL %s @%0t act=%h exp=%h mask=%h", name, $time, act, e, m);
        else
            n_pass++;
    endtask

    always @(negedge clk) begin
        if (q2.size() > 0)
            mon_cmp("sb_2way", {bus2.hit_cnt, bus2.miss_cnt, bus2.err, bus2.hit, bus2.dirty,
                                bus2.valid, bus2.tag_out, bus2.data_out}, q2.pop_front());
        if (q4.size() > 0)
            mon_cmp("sb_4way", {bus4.hit_cnt, bus4.miss_cnt, bus4.err, bus4.hit, bus4.dirty,
                                bus4.valid, bus4.tag_out, bus4.data_out}, q4.pop_front());
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s act=%h exp=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic issue(input bit en, input bit comp, input bit wr, input bit vin,
                         input logic [4:0] tag, input logic [7:0] idx,
                         input logic [2:0] off, input logic [15:0] d);
        @(posedge clk);
        #1;
        t_en = en; t_comp = comp; t_write = wr; t_vin = vin;
        t_tag = tag; t_idx = idx; t_off = off; t_data = d;
        q2.push_back(m_step(0));
        q4.push_back(m_step(1));
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic fill(input logic [4:0] tag, input logic [7:0] idx);
        for (int o = 0; o < 8; o += 2)
            issue(1, 0, 1, 1, tag, idx, 3'(o), 16'(int'(tag) * 256 + o));
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        t_en = 1'b0;
        rst = 1'b0;
        m_reset();
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        m_reset();
        #12 rst = 1'b1;

        // cold miss
        issue(1, 1, 0, 0, 5'h3, 8'h10, 3'd0, 16'h0); look();
        chk("cold_hit", {bus2.hit, bus4.hit}, 0);
        chk("cold_valid", {bus2.valid, bus4.valid}, 0);
        chk("cold_dirty_err", {bus2.dirty, bus2.err, bus4.dirty, bus4.err}, 0);

        // four-word fill stays in way0
        fill(5'h3, 8'h10);
        issue(1, 1, 0, 0, 5'h3, 8'h10, 3'd4, 16'h0); look();
        chk("fill_hit", {bus2.hit, bus4.hit}, 2'b11);
        chk("fill_data2", bus2.data_out, 16'h0304);
        chk("fill_data4", bus4.data_out, 16'h0304);

        // second line, re-touch first, victim is the second
        issue(1, 1, 0, 0, 5'h7, 8'h10, 3'd0, 16'h0);
        fill(5'h7, 8'h10);
        issue(1, 1, 0, 0, 5'h3, 8'h10, 3'd0, 16'h0);
        issue(1, 0, 0, 0, 5'h0, 8'h10, 3'd0, 16'h0); look();
        chk("victim_tag2", bus2.tag_out, 5'h7);

        // compare write hit then miss
        issue(1, 1, 1, 0, 5'h3, 8'h10, 3'd2, 16'hBEEF);
        issue(1, 1, 0, 0, 5'h3, 8'h10, 3'd2, 16'h0); look();
        chk("cw_data", {bus2.data_out, bus4.data_out}, 32'hBEEFBEEF);
        chk("cw_dirty", {bus2.dirty, bus4.dirty}, 2'b11);
        issue(1, 1, 1, 0, 5'h9, 8'h10, 3'd2, 16'h1234); look();
        chk("cw_miss_hit", {bus2.hit, bus4.hit}, 0);
        issue(1, 1, 0, 0, 5'h3, 8'h10, 3'd2, 16'h0); look();
        chk("cw_miss_keep", {bus2.data_out, bus4.data_out}, 32'hBEEFBEEF);

        // tree PLRU walk
        issue(1, 1, 0, 0, 5'hA, 8'h10, 3'd0, 16'h0);
        fill(5'hA, 8'h10);
        issue(1, 1, 0, 0, 5'hB, 8'h10, 3'd0, 16'h0);
        fill(5'hB, 8'h10);
        issue(1, 1, 0, 0, 5'hA, 8'h10, 3'd0, 16'h0);
        issue(1, 1, 0, 0, 5'h3, 8'h10, 3'd0, 16'h0);
        issue(1, 0, 0, 0, 5'h0, 8'h10, 3'd0, 16'h0); look();
        chk("plru_tag4", bus4.tag_out, 5'hB);
        chk("plru_tag2", bus2.tag_out, 5'hB);

        // odd offset
        issue(1, 0, 1, 1, 5'h3, 8'h10, 3'b001, 16'hDEAD); look();
        chk("err_flag", {bus2.err, bus4.err}, 2'b11);
        chk("err_quiet", {bus2.hit, bus2.valid, bus2.data_out, bus4.valid, bus4.data_out}, 0);

        // reset in the middle of a fill
        issue(1, 0, 1, 1, 5'h5, 8'h20, 3'd0, 16'h5500);
        issue(1, 0, 1, 1, 5'h5, 8'h20, 3'd2, 16'h5502);
        pulse_reset();

        // statistics: three hits, two misses
        issue(1, 0, 1, 1, 5'h1, 8'h30, 3'd0, 16'h0101);
        for (int i = 0; i < 3; i++) issue(1, 1, 0, 0, 5'h1, 8'h30, 3'd0, 16'h0);
        for (int i = 0; i < 2; i++) issue(1, 1, 0, 0, 5'h2, 8'h30, 3'd0, 16'h0);
        issue(0, 0, 0, 0, 5'h0, 8'h0, 3'd0, 16'h0); look();
        chk("idle_zero", {bus2.valid, bus2.tag_out, bus2.data_out, bus4.hit, bus4.err}, 0);
`ifdef CACHE_STATS_EN
        chk("stats_cnt", {bus2.hit_cnt, bus4.miss_cnt}, {16'd3, 16'd2});
`else
        chk("stats_cnt", {bus2.hit_cnt, bus4.miss_cnt}, 0);
`endif
        issue(1, 1, 0, 0, 5'h5, 8'h20, 3'd0, 16'h0); look();
        chk("rst_miss", {bus2.hit, bus4.hit}, 0);
        issue(1, 0, 0, 0, 5'h0, 8'h20, 3'd0, 16'h0); look();
        chk("rst_invalid", {bus2.valid, bus4.valid}, 0);

        // random traffic over a few sets and tags
        for (int i = 0; i < 400; i++) begin
            logic [2:0] off;
            off = 3'($urandom_range(0, 3) * 2);
            if ($urandom_range(0, 15) == 0) off[0] = 1'b1;
            issue($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                  8'(8'h40 + $urandom_range(0, 2)), off, 16'($urandom));
        end
        issue(0, 0, 0, 0, 5'h0, 8'h0, 3'd0, 16'h0);
        repeat (2) look();
        chk("drain", q2.size() + q4.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
